// File: rtl/sdram_arbiter_if.sv
// Bus bundle between the SDRAM arbiter, its two clients and the SDRAM controller.
// The master modport is the arbiter's view; the slave modport is everything around it.
interface sdram_arbiter_if #(
    parameter int ADDR_W = 22,
    parameter int DATA_W = 32
);
    logic              i_Disp_Req;
    logic              o_Disp_Grant;
    logic [1:0]        i_Disp_Command;
    logic [ADDR_W-1:0] i_Disp_Address;
    logic [DATA_W-1:0] i_Disp_Data_Write;
    logic              o_Disp_Read_Valid;
    logic              o_Disp_Write_Done;

    logic              o_Comp_Requested;
    logic              i_Comp_Yield;
    logic [1:0]        i_Comp_Command;
    logic [ADDR_W-1:0] i_Comp_Address;
    logic [DATA_W-1:0] i_Comp_Data_Write;
    logic              o_Comp_Read_Valid;
    logic              o_Comp_Write_Done;

    logic [1:0]        o_Command;
    logic [ADDR_W-1:0] o_Data_Address;
    logic [DATA_W-1:0] o_Data_Write;
    logic              i_Data_Read_Valid;
    logic              i_Data_Write_Done;

    logic              o_Yield_Timeout;

    modport master (
        input  i_Disp_Req, i_Disp_Command, i_Disp_Address, i_Disp_Data_Write,
        output o_Disp_Grant, o_Disp_Read_Valid, o_Disp_Write_Done,
        input  i_Comp_Yield, i_Comp_Command, i_Comp_Address, i_Comp_Data_Write,
        output o_Comp_Requested, o_Comp_Read_Valid, o_Comp_Write_Done,
        output o_Command, o_Data_Address, o_Data_Write,
        input  i_Data_Read_Valid, i_Data_Write_Done,
        output o_Yield_Timeout
    );

    modport slave (
        output i_Disp_Req, i_Disp_Command, i_Disp_Address, i_Disp_Data_Write,
        input  o_Disp_Grant, o_Disp_Read_Valid, o_Disp_Write_Done,
        output i_Comp_Yield, i_Comp_Command, i_Comp_Address, i_Comp_Data_Write,
        input  o_Comp_Requested, o_Comp_Read_Valid, o_Comp_Write_Done,
        input  o_Command, o_Data_Address, o_Data_Write,
        output i_Data_Read_Valid, i_Data_Write_Done,
        input  o_Yield_Timeout
    );
endinterface

// File: rtl/sdram_arbiter.sv
// Shares the SDRAM controller port between the display reader (priority) and the
// compute engine (default owner) using the request/yield handshake.
module sdram_arbiter #(
    parameter int ADDR_W        = 22,
    parameter int DATA_W        = 32,
    parameter int YIELD_TIMEOUT = 1024,
    parameter int TO_W          = 11
) (
    input  logic           i_Clk,
    input  logic           i_Reset,
    sdram_arbiter_if.master bus
);
    localparam logic [1:0]      CMD_IDLE = 2'd0;
    localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(YIELD_TIMEOUT);

    typedef enum logic [2:0] {
        COMP_OWN,
        WAIT_YIELD,
        HAND_TO_DISP,
        DISP_OWN,
        HAND_TO_COMP
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [TO_W-1:0] wait_count_q;
    logic [TO_W-1:0] wait_count_d;
    logic            timeout_q;

    always_ff @(posedge i_Clk) begin
        if (i_Reset) begin
            state_q      <= COMP_OWN;
            wait_count_q <= '0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wait_count_q <= wait_count_d;
            if (wait_count_d == TO_LIMIT) begin
                timeout_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            COMP_OWN: begin
                if (bus.i_Disp_Req) begin
                    state_d = WAIT_YIELD;
                end
            end
            WAIT_YIELD: begin
                // A withdrawn request wins over a yield arriving in the same cycle.
                if (!bus.i_Disp_Req) begin
                    state_d = COMP_OWN;
                end else if (bus.i_Comp_Yield) begin
                    state_d = HAND_TO_DISP;
                end
            end
            HAND_TO_DISP: state_d = DISP_OWN;
            DISP_OWN: begin
                if (!bus.i_Disp_Req && bus.i_Disp_Command == CMD_IDLE) begin
                    state_d = HAND_TO_COMP;
                end
            end
            HAND_TO_COMP: state_d = COMP_OWN;
            default:      state_d = COMP_OWN;
        endcase
    end

    // Counts only while the wait continues; any exit from WAIT_YIELD clears it.
    always_comb begin
        wait_count_d = '0;
        if (state_q == WAIT_YIELD && state_d == WAIT_YIELD) begin
            wait_count_d = (wait_count_q == TO_LIMIT) ? wait_count_q
                                                      : wait_count_q + 1'b1;
        end
    end

    always_comb begin
        bus.o_Comp_Requested  = 1'b1;
        bus.o_Disp_Grant      = 1'b0;
        bus.o_Command         = CMD_IDLE;
        bus.o_Data_Address    = {ADDR_W{1'b0}};
        bus.o_Data_Write      = {DATA_W{1'b0}};
        bus.o_Disp_Read_Valid = 1'b0;
        bus.o_Disp_Write_Done = 1'b0;
        bus.o_Comp_Read_Valid = 1'b0;
        bus.o_Comp_Write_Done = 1'b0;
        case (state_q)
            COMP_OWN, WAIT_YIELD: begin
                bus.o_Comp_Requested  = (state_q == WAIT_YIELD);
                bus.o_Command         = bus.i_Comp_Command;
                bus.o_Data_Address    = bus.i_Comp_Address;
                bus.o_Data_Write      = bus.i_Comp_Data_Write;
                bus.o_Comp_Read_Valid = bus.i_Data_Read_Valid;
                bus.o_Comp_Write_Done = bus.i_Data_Write_Done;
            end
            DISP_OWN: begin
                bus.o_Disp_Grant      = 1'b1;
                bus.o_Command         = bus.i_Disp_Command;
                bus.o_Data_Address    = bus.i_Disp_Address;
                bus.o_Data_Write      = bus.i_Disp_Data_Write;
                bus.o_Disp_Read_Valid = bus.i_Data_Read_Valid;
                bus.o_Disp_Write_Done = bus.i_Data_Write_Done;
            end
            default: begin
                bus.o_Comp_Requested = 1'b1;
            end
        endcase
    end

    assign bus.o_Yield_Timeout = timeout_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: reset, grant latency, mid-burst hold,
// withdrawal, hand-back, yield timeout and reset while the display owns the bus.
module tb_sdram_arbiter;
    localparam logic [1:0] CMD_IDLE  = 2'd0;
    localparam logic [1:0] CMD_READ  = 2'd1;
    localparam logic [1:0] CMD_WRITE = 2'd2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   compared   = 0;
    int   mismatched = 0;

    sdram_arbiter_if #(.ADDR_W(22), .DATA_W(32)) bus ();

    sdram_arbiter #(
        .ADDR_W(22), .DATA_W(32), .YIELD_TIMEOUT(1024), .TO_W(11)
    ) dut (
        .i_Clk   (clk),
        .i_Reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic go_to_disp();
        bus.i_Disp_Req   = 1'b1;
        bus.i_Comp_Yield = 1'b1;
        step();
        step();
        step();
    endtask

    task automatic test_reset();
        reset_dut();
        bus.i_Comp_Command    = CMD_READ;
        bus.i_Comp_Address    = 22'h00123;
        bus.i_Comp_Data_Write = 32'hCAFE_0001;
        bus.i_Data_Read_Valid = 1'b1;
        #1;
        compared++; if (bus.o_Comp_Requested !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_req got=%b exp=0", bus.o_Comp_Requested); end
        compared++; if (bus.o_Disp_Grant !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_grant got=%b exp=0", bus.o_Disp_Grant); end
        compared++; if (bus.o_Yield_Timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_timeout got=%b exp=0", bus.o_Yield_Timeout); end
        compared++; if (bus.o_Command !== CMD_READ) begin mismatched++; $display("[TB] FAIL reset_cmd got=%0d exp=%0d", bus.o_Command, CMD_READ); end
        compared++; if (bus.o_Data_Address !== 22'h00123) begin mismatched++; $display("[TB] FAIL reset_addr got=%h exp=00123", bus.o_Data_Address); end
        compared++; if (bus.o_Data_Write !== 32'hCAFE_0001) begin mismatched++; $display("[TB] FAIL reset_wdata got=%h exp=cafe0001", bus.o_Data_Write); end
        compared++; if ({bus.o_Comp_Read_Valid, bus.o_Disp_Read_Valid} !== 2'b10) begin mismatched++; $display("[TB] FAIL reset_rv_route got=%b exp=10", {bus.o_Comp_Read_Valid, bus.o_Disp_Read_Valid}); end
        bus.i_Data_Read_Valid = 1'b0;
    endtask

    task automatic test_grant();
        bus.i_Comp_Yield      = 1'b1;
        bus.i_Disp_Address    = 22'h20000;
        bus.i_Disp_Command    = CMD_IDLE;
        bus.i_Disp_Data_Write = 32'hD15D_0000;
        bus.i_Disp_Req        = 1'b1;
        #1;
        compared++; if (bus.o_Comp_Requested !== 1'b0) begin mismatched++; $display("[TB] FAIL grant_n_req got=%b exp=0", bus.o_Comp_Requested); end
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b10) begin mismatched++; $display("[TB] FAIL grant_n1 req/grant got=%b exp=10", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        compared++; if (bus.o_Data_Address !== 22'h00123) begin mismatched++; $display("[TB] FAIL grant_n1_addr got=%h exp=00123", bus.o_Data_Address); end
        step();
        bus.i_Data_Read_Valid = 1'b1;
        bus.i_Data_Write_Done = 1'b1;
        #1;
        compared++; if (bus.o_Command !== CMD_IDLE) begin mismatched++; $display("[TB] FAIL grant_n2_cmd got=%0d exp=0", bus.o_Command); end
        compared++; if (bus.o_Data_Address !== 22'h0) begin mismatched++; $display("[TB] FAIL grant_n2_addr got=%h exp=0", bus.o_Data_Address); end
        compared++; if (bus.o_Data_Write !== 32'h0) begin mismatched++; $display("[TB] FAIL grant_n2_wdata got=%h exp=0", bus.o_Data_Write); end
        compared++; if ({bus.o_Comp_Read_Valid, bus.o_Disp_Read_Valid, bus.o_Comp_Write_Done, bus.o_Disp_Write_Done} !== 4'b0000) begin mismatched++; $display("[TB] FAIL grant_n2_strobes got=%b exp=0000", {bus.o_Comp_Read_Valid, bus.o_Disp_Read_Valid, bus.o_Comp_Write_Done, bus.o_Disp_Write_Done}); end
        compared++; if (bus.o_Disp_Grant !== 1'b0) begin mismatched++; $display("[TB] FAIL grant_n2_grant got=%b exp=0", bus.o_Disp_Grant); end
        bus.i_Data_Read_Valid = 1'b0;
        step();
        compared++; if (bus.o_Disp_Grant !== 1'b1) begin mismatched++; $display("[TB] FAIL grant_n3_grant got=%b exp=1", bus.o_Disp_Grant); end
        compared++; if (bus.o_Data_Address !== 22'h20000) begin mismatched++; $display("[TB] FAIL grant_n3_addr got=%h exp=20000", bus.o_Data_Address); end
        compared++; if ({bus.o_Disp_Write_Done, bus.o_Comp_Write_Done} !== 2'b10) begin mismatched++; $display("[TB] FAIL grant_n3_wd_route got=%b exp=10", {bus.o_Disp_Write_Done, bus.o_Comp_Write_Done}); end
        bus.i_Data_Write_Done = 1'b0;
    endtask

    task automatic test_mid_burst();
        bus.i_Disp_Command = CMD_READ;
        bus.i_Disp_Req     = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bus.i_Data_Read_Valid = 1'b1;
            #1;
            compared++; if (bus.o_Disp_Grant !== 1'b1) begin mismatched++; $display("[TB] FAIL burst_hold_%0d got=%b exp=1", i, bus.o_Disp_Grant); end
            compared++; if ({bus.o_Disp_Read_Valid, bus.o_Comp_Read_Valid} !== 2'b10) begin mismatched++; $display("[TB] FAIL burst_rv_%0d got=%b exp=10", i, {bus.o_Disp_Read_Valid, bus.o_Comp_Read_Valid}); end
            compared++; if (bus.o_Command !== CMD_READ) begin mismatched++; $display("[TB] FAIL burst_cmd_%0d got=%0d exp=1", i, bus.o_Command); end
            step();
        end
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Disp_Command    = CMD_IDLE;
        #1;
        compared++; if (bus.o_Disp_Grant !== 1'b1) begin mismatched++; $display("[TB] FAIL release_m_grant got=%b exp=1", bus.o_Disp_Grant); end
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b10) begin mismatched++; $display("[TB] FAIL release_m1 req/grant got=%b exp=10", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        compared++; if (bus.o_Command !== CMD_IDLE) begin mismatched++; $display("[TB] FAIL release_m1_cmd got=%0d exp=0", bus.o_Command); end
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b00) begin mismatched++; $display("[TB] FAIL release_m2 req/grant got=%b exp=00", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        compared++; if (bus.o_Command !== CMD_READ) begin mismatched++; $display("[TB] FAIL release_m2_cmd got=%0d exp=1", bus.o_Command); end
    endtask

    task automatic test_withdraw();
        bus.i_Comp_Yield = 1'b0;
        bus.i_Disp_Req   = 1'b1;
        step();
        bus.i_Disp_Req = 1'b0;
        #1;
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b10) begin mismatched++; $display("[TB] FAIL withdraw_wait got=%b exp=10", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b00) begin mismatched++; $display("[TB] FAIL withdraw_back got=%b exp=00", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b00) begin mismatched++; $display("[TB] FAIL withdraw_idle got=%b exp=00", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        // Withdrawal and yield together must fall back to compute.
        bus.i_Disp_Req = 1'b1;
        step();
        bus.i_Disp_Req   = 1'b0;
        bus.i_Comp_Yield = 1'b1;
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b00) begin mismatched++; $display("[TB] FAIL withdraw_prio got=%b exp=00", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        compared++; if (bus.o_Command !== CMD_READ) begin mismatched++; $display("[TB] FAIL withdraw_prio_cmd got=%0d exp=1", bus.o_Command); end
        bus.i_Comp_Yield = 1'b0;
    endtask

    task automatic test_back_to_back();
        go_to_disp();
        compared++; if (bus.o_Disp_Grant !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_grant got=%b exp=1", bus.o_Disp_Grant); end
        bus.i_Disp_Req = 1'b0;
        step();
        bus.i_Disp_Req = 1'b1;
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b00) begin mismatched++; $display("[TB] FAIL b2b_comp_cycle got=%b exp=00", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b10) begin mismatched++; $display("[TB] FAIL b2b_rewait got=%b exp=10", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        step();
        step();
        compared++; if (bus.o_Disp_Grant !== 1'b1) begin mismatched++; $display("[TB] FAIL b2b_regrant got=%b exp=1", bus.o_Disp_Grant); end
        bus.i_Disp_Req = 1'b0;
        step();
        step();
    endtask

    task automatic test_timeout();
        reset_dut();
        bus.i_Comp_Yield = 1'b0;
        bus.i_Disp_Req   = 1'b1;
        step();
        for (int i = 0; i < 1100; i++) begin
            if (i == 1023) begin
                compared++; if (bus.o_Yield_Timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_early got=%b exp=0", bus.o_Yield_Timeout); end
            end
            if (i == 1024 || i == 1099) begin
                compared++; if (bus.o_Yield_Timeout !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_set_%0d got=%b exp=1", i, bus.o_Yield_Timeout); end
            end
            step();
        end
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b10) begin mismatched++; $display("[TB] FAIL timeout_still_wait got=%b exp=10", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        bus.i_Comp_Yield = 1'b1;
        step();
        step();
        compared++; if ({bus.o_Disp_Grant, bus.o_Yield_Timeout} !== 2'b11) begin mismatched++; $display("[TB] FAIL timeout_sticky got=%b exp=11", {bus.o_Disp_Grant, bus.o_Yield_Timeout}); end
        bus.i_Disp_Req = 1'b0;
        reset_dut();
        compared++; if (bus.o_Yield_Timeout !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_cleared got=%b exp=0", bus.o_Yield_Timeout); end
    endtask

    task automatic test_reset_mid_grant();
        go_to_disp();
        bus.i_Comp_Command = CMD_WRITE;
        bus.i_Comp_Address = 22'h003AB;
        rst = 1'b1;
        step();
        compared++; if ({bus.o_Comp_Requested, bus.o_Disp_Grant} !== 2'b00) begin mismatched++; $display("[TB] FAIL rst_grant req/grant got=%b exp=00", {bus.o_Comp_Requested, bus.o_Disp_Grant}); end
        compared++; if (bus.o_Command !== CMD_WRITE) begin mismatched++; $display("[TB] FAIL rst_grant_cmd got=%0d exp=2", bus.o_Command); end
        compared++; if (bus.o_Data_Address !== 22'h003AB) begin mismatched++; $display("[TB] FAIL rst_grant_addr got=%h exp=003ab", bus.o_Data_Address); end
        rst = 1'b0;
        bus.i_Disp_Req = 1'b0;
        step();
    endtask

    initial begin
        bus.i_Disp_Req        = 1'b0;
        bus.i_Disp_Command    = CMD_IDLE;
        bus.i_Disp_Address    = '0;
        bus.i_Disp_Data_Write = '0;
        bus.i_Comp_Yield      = 1'b0;
        bus.i_Comp_Command    = CMD_IDLE;
        bus.i_Comp_Address    = '0;
        bus.i_Comp_Data_Write = '0;
        bus.i_Data_Read_Valid = 1'b0;
        bus.i_Data_Write_Done = 1'b0;
        test_reset();
        test_grant();
        test_mid_burst();
        test_withdraw();
        test_back_to_back();
        test_timeout();
        test_reset_mid_grant();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Shares the single SDRAM controller port between two clients: the LCD display refresh reader (display client, high priority) and the fractal compute engine (compute client, default owner).
- Uses the existing request/yield handshake: the arbiter raises o_Comp_Requested, and the compute engine answers with i_Comp_Yield once it is idle.
- Sits between both clients and the SDRAM controller.
- Muxes command, address and write data to the controller, and routes the read-valid and write-done strobes back to the current owner only.

Parameters:
- ADDR_W, 22, SDRAM word address width.
- DATA_W, 32, SDRAM data width.
- YIELD_TIMEOUT, 1024, cycles in WAIT_YIELD before the timeout flag sets.
- TO_W, 11, width of the timeout counter; must hold YIELD_TIMEOUT.

Ports:
- i_Clk  in  1  single clock; the SDRAM controller domain.
- i_Reset  in  1  synchronous, active-high reset.
- i_Disp_Req  in  1  display client requests bus ownership.
- o_Disp_Grant  out  1  display client owns the bus.
- i_Disp_Command  in  2  display command: CMD_IDLE, CMD_READ or CMD_WRITE, from the shared SDRAM header.
- i_Disp_Address  in  ADDR_W  display address.
- i_Disp_Data_Write  in  DATA_W  display write data.
- o_Disp_Read_Valid  out  1  read-valid strobe, routed to the display client.
- o_Disp_Write_Done  out  1  write-done strobe, routed to the display client.
- o_Comp_Requested  out  1  asks the compute client to park.
- i_Comp_Yield  in  1  compute client is idle and has released the bus.
- i_Comp_Command  in  2  compute command.
- i_Comp_Address  in  ADDR_W  compute address.
- i_Comp_Data_Write  in  DATA_W  compute write data.
- o_Comp_Read_Valid  out  1  read-valid strobe, routed to the compute client.
- o_Comp_Write_Done  out  1  write-done strobe, routed to the compute client.
- o_Command  out  2  command to the SDRAM controller.
- o_Data_Address  out  ADDR_W  address to the SDRAM controller.
- o_Data_Write  out  DATA_W  write data to the SDRAM controller.
- i_Data_Read_Valid  in  1  read-valid from the controller.
- i_Data_Write_Done  in  1  write-done from the controller.
- o_Yield_Timeout  out  1  sticky error flag.

Behaviour:
- Read data (i_Data_Read) fans out directly from the controller to both clients and does not pass through this block.
- States: COMP_OWN, WAIT_YIELD, HAND_TO_DISP, DISP_OWN, HAND_TO_COMP. The state register is the only arbitration storage.
- Reset: state COMP_OWN, timeout counter 0, o_Yield_Timeout 0.
- Reset taken mid-operation (any state): next cycle is COMP_OWN with o_Comp_Requested=0 and o_Disp_Grant=0. Any in-flight burst is abandoned; the controller is reset by the same i_Reset.
- Outputs decoded from registered state:
  - o_Comp_Requested=1 in WAIT_YIELD, HAND_TO_DISP, DISP_OWN and HAND_TO_COMP.
  - o_Disp_Grant=1 only in DISP_OWN.
- Mux:
  - COMP_OWN and WAIT_YIELD: o_Command/o_Data_Address/o_Data_Write come from the compute inputs.
  - DISP_OWN: the same outputs come from the display inputs.
  - HAND_TO_DISP and HAND_TO_COMP: o_Command=CMD_IDLE, o_Data_Address=0, o_Data_Write=0.
- Strobe routing:
  - i_Data_Read_Valid and i_Data_Write_Done go to the owner's outputs only.
  - The owner is compute in COMP_OWN and WAIT_YIELD, display in DISP_OWN.
  - Both clients see 0 in the handover states.
- Transitions:
  - COMP_OWN -> WAIT_YIELD when i_Disp_Req=1.
  - WAIT_YIELD -> COMP_OWN when i_Disp_Req=0 (request withdrawn). This takes priority over a simultaneous i_Comp_Yield.
  - WAIT_YIELD -> HAND_TO_DISP when i_Comp_Yield=1 and i_Disp_Req=1.
  - HAND_TO_DISP -> DISP_OWN unconditionally.
  - DISP_OWN -> HAND_TO_COMP when i_Disp_Req=0 and i_Disp_Command=CMD_IDLE. If the request drops while a command is still active, ownership is held until the command goes idle, which protects a mid-burst transfer.
  - HAND_TO_COMP -> COMP_OWN unconditionally.
  - Compute regains the bus for at least one cycle even if i_Disp_Req reasserts in HAND_TO_COMP. The COMP_OWN cycle then re-enters WAIT_YIELD.
- Latency, request and grant: i_Disp_Req first high at cycle N with compute idle gives WAIT_YIELD at N+1, HAND_TO_DISP at N+2 and o_Disp_Grant=1 at N+3.
- Latency, release: release condition at cycle M gives HAND_TO_COMP at M+1 and o_Comp_Requested=0 at M+2.
- Timeout counter:
  - Increments each cycle in WAIT_YIELD and saturates at YIELD_TIMEOUT.
  - Clears on leaving WAIT_YIELD.
  - On reaching YIELD_TIMEOUT, o_Yield_Timeout sets and stays 1 until reset.
  - The timeout does not alter arbitration.
- Invariant: o_Disp_Grant and compute ownership are never simultaneously asserted, and every change of owner is separated by at least one CMD_IDLE cycle.

Test Plan:
- Reset: hold i_Reset 2 cycles -> COMP_OWN; o_Comp_Requested=0, o_Disp_Grant=0, o_Yield_Timeout=0; compute CMD_READ at address 22'h00123 appears on o_Command/o_Data_Address.
- Grant: i_Disp_Req rises at cycle 10 with i_Comp_Yield=1 -> o_Comp_Requested=1 at 11; o_Command=CMD_IDLE at 12; o_Disp_Grant=1 at 13; display address 22'h20000 then drives o_Data_Address.
- Mid-burst release: i_Disp_Req drops while i_Disp_Command=CMD_READ with 3 read-valid strobes remaining -> grant is held; all 3 strobes appear on o_Disp_Read_Valid and none on o_Comp_Read_Valid; handover follows the first CMD_IDLE cycle.
- Withdrawal: i_Disp_Req pulses for 1 cycle while i_Comp_Yield=0 -> WAIT_YIELD for 1 cycle, then COMP_OWN; o_Disp_Grant never asserts.
- Timeout: i_Disp_Req held high, i_Comp_Yield=0 for 1100 cycles -> o_Yield_Timeout=1 from WAIT_YIELD cycle 1024 onward; the flag stays set after a later grant and clears only on i_Reset.
- Reset mid-grant: assert i_Reset in DISP_OWN -> next cycle o_Disp_Grant=0, o_Comp_Requested=0, and o_Command follows the compute inputs.
